// File: rtl/sin_pkg.sv
// Shared constants and stage bundles for the sin argument
// range-reduction pipeline.
package sin_pkg;

  localparam int FLT_W     = 32;
  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int FIX_W     = 48;
  localparam int FRAC_BITS = 40;

  localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;
  localparam logic [EXP_W-1:0] EXP_OOR  = 8'd134;
  // Exponent at which the mantissa lands unshifted in Q8.40
  localparam logic [EXP_W-1:0] EXP_ALIGN =
    EXP_BIAS + 8'(MAN_W) - 8'(FRAC_BITS);
  localparam logic [EXP_W-1:0] EXP_MIN = EXP_ALIGN - 8'(MAN_W);

  localparam logic [47:0] TWO_OVER_PI = 48'hA2F9836E4E44;
  localparam logic [31:0] PI_OVER_2   = 32'h6487ED51;

  localparam logic [47:0] HALF_P = 48'h0080_0000_0000;
  localparam logic [40:0] HALF_F = 41'h080_0000_0000;

  typedef struct packed {
    logic              nan;
    logic              oor;
    logic signed [47:0] a;
  } s1_t;

  typedef struct packed {
    logic              nan;
    logic              oor;
    logic signed [7:0]  k;
    logic signed [40:0] f;
  } s2_t;

  typedef struct packed {
    logic              nan;
    logic              oor;
    logic [1:0]        quadrant;
    logic [31:0]       angle;
  } s3_t;

endpackage

// File: rtl/float_align.sv
// Float32 unpack into signed Q8.40 with nan / out-of-range
// flag generation.
module float_align
  import sin_pkg::*;
(
  input  logic [FLT_W-1:0] bits,
  output s1_t              s1
);

  logic             sign;
  logic [EXP_W-1:0] exp_f;
  logic [FIX_W-1:0] man;
  logic [FIX_W-1:0] mag;
  logic             nan;
  logic             oor;
  logic             tiny;

  assign sign  = bits[FLT_W-1];
  assign exp_f = bits[FLT_W-2 -: EXP_W];
  assign man   = {{(FIX_W-MAN_W-1){1'b0}}, 1'b1, bits[MAN_W-1:0]};

  assign nan  = &exp_f;
  assign oor  = !nan && (exp_f >= EXP_OOR);
  // Also covers zero and denormals
  assign tiny = exp_f < EXP_MIN;

  always_comb begin
    mag = '0;
    if (exp_f >= EXP_ALIGN)
      mag = man << (exp_f - EXP_ALIGN);
    else
      mag = man >> (EXP_ALIGN - exp_f);
    if (tiny || nan || oor)
      mag = '0;
  end

  assign s1.nan = nan;
  assign s1.oor = oor;
  assign s1.a   = sign ? (~mag + 1'b1) : mag;

endmodule

// File: rtl/sin_range_reduce.sv
// Three-stage modulo pi/2 range reduction ahead of the
// sin CORDIC core: align, scale by 2/pi, rescale by pi/2.
module sin_range_reduce
  import sin_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [31:0] io_in_bits,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_angle,
  output logic [1:0]  io_out_quadrant,
  output logic        io_out_nan,
  output logic        io_out_oor
);

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;

  logic v1, v2, v3;
  logic ld1, ld2, ld3;

  logic signed [96:0] prod_p;
  logic        [47:0] p_rnd;
  logic signed [73:0] prod_a;
  logic               flag2;
  logic               unused_bits;

  float_align u_align (
    .bits (io_in_bits),
    .s1   (s1_d)
  );

  assign ld3 = !v3 || io_out_ready;
  assign ld2 = !v2 || ld3;
  assign ld1 = !v1 || ld2;
  assign io_in_ready = ld1;

  // p = a*2/pi; k rounds half up; f is the centred remainder
  always_comb begin
    prod_p   = $signed(s1_q.a) * $signed({1'b0, TWO_OVER_PI});
    p_rnd    = prod_p[95:48] + HALF_P;
    s2_d.nan = s1_q.nan;
    s2_d.oor = s1_q.oor;
    s2_d.k   = p_rnd[47:40];
    s2_d.f   = {1'b0, p_rnd[39:0]} - HALF_F;
  end

  assign flag2 = s2_q.nan || s2_q.oor;

  always_comb begin
    prod_a        = $signed(s2_q.f) * $signed({1'b0, PI_OVER_2});
    s3_d.nan      = s2_q.nan;
    s3_d.oor      = s2_q.oor;
    s3_d.quadrant = flag2 ? 2'd0 : s2_q.k[1:0];
    s3_d.angle    = flag2 ? 32'd0 : prod_a[71:40];
  end

  assign unused_bits = ^{prod_p[96], prod_p[47:0],
                         prod_a[73:72], prod_a[39:0],
                         s2_q.k[7:2]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      if (ld1) v1 <= io_in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
      if (ld1 && io_in_valid) s1_q <= s1_d;
      if (ld2 && v1) s2_q <= s2_d;
      if (ld3 && v2) s3_q <= s3_d;
    end
  end

  assign io_out_valid    = v3;
  assign io_out_angle    = s3_q.angle;
  assign io_out_quadrant = s3_q.quadrant;
  assign io_out_nan      = s3_q.nan;
  assign io_out_oor      = s3_q.oor;

endmodule

// File: tb/tb_sin_range_reduce.sv
// Directed self-checking bench for sin_range_reduce.
// Expected angles are x - k*pi/2 in Q2.30 from the exact float input.
`timescale 1ns/1ps
module tb_sin_range_reduce;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [31:0] io_in_bits = '0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b1;
  logic [31:0] io_out_angle;
  logic [1:0]  io_out_quadrant;
  logic        io_out_nan;
  logic        io_out_oor;

  int n_checks = 0;
  int n_fail   = 0;

  localparam real PI = 3.14159265358979323846;

  always #5 clock = ~clock;

  sin_range_reduce dut (
    .clock           (clock),
    .reset           (reset),
    .io_in_valid     (io_in_valid),
    .io_in_ready     (io_in_ready),
    .io_in_bits      (io_in_bits),
    .io_out_valid    (io_out_valid),
    .io_out_ready    (io_out_ready),
    .io_out_angle    (io_out_angle),
    .io_out_quadrant (io_out_quadrant),
    .io_out_nan      (io_out_nan),
    .io_out_oor      (io_out_oor)
  );

  // Push one value into an empty pipe, wait (bounded) for its result
  task automatic run_vec(input logic [31:0] x, output int ang,
                         output logic [1:0] q, output logic n,
                         output logic o, output int lat);
    io_out_ready = 1'b1;
    io_in_bits   = x;
    io_in_valid  = 1'b1;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    lat = 1;
    while (!io_out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    ang = $signed(io_out_angle);
    q   = io_out_quadrant;
    n   = io_out_nan;
    o   = io_out_oor;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (io_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", io_out_valid);
    end
    n_checks++;
    if (io_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", io_in_ready);
    end
    n_checks++;
    if ({io_out_angle, io_out_quadrant, io_out_nan, io_out_oor} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: angle=%h quad=%0d nan=%b oor=%b want all 0",
               io_out_angle, io_out_quadrant, io_out_nan, io_out_oor);
    end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_mid_range;
    int ang, lat;
    logic [1:0] q;
    logic n, o;
    // +5pi/8 (this exact float is pi/8 + ~859 LSB past pi/2)
    run_vec(32'h3ffb53d8, ang, q, n, o, lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL pos_latency: got %0d want 3", lat);
    end
    n_checks++;
    if (q !== 2'd1) begin
      n_fail++;
      $display("FAIL pos_quadrant: got %0d want 1", q);
    end
    n_checks++;
    if (ang < 421658287 - 64 || ang > 421658287 + 64) begin
      n_fail++;
      $display("FAIL pos_angle: got %0d want 421658287 +-64", ang);
    end
    n_checks++;
    if ({n, o} !== 2'b00) begin
      n_fail++;
      $display("FAIL pos_flags: got nan=%b oor=%b want 0 0", n, o);
    end
    run_vec(32'hbffb53d8, ang, q, n, o, lat);
    n_checks++;
    if (q !== 2'd3) begin
      n_fail++;
      $display("FAIL neg_quadrant: got %0d want 3", q);
    end
    n_checks++;
    if (ang < -421658287 - 64 || ang > -421658287 + 64) begin
      n_fail++;
      $display("FAIL neg_angle: got %0d want -421658287 +-64", ang);
    end
  endtask

  task automatic test_large_zero;
    int ang, lat;
    logic [1:0] q;
    logic n, o;
    logic [31:0] zv [3];
    zv[0] = 32'h00000000;
    zv[1] = 32'h80000000;
    zv[2] = 32'h00000001;
    // ~20pi: 1e-5 rad is 10737 LSB
    run_vec(32'h427b53d2, ang, q, n, o, lat);
    n_checks++;
    if (q !== 2'd0 || ang <= -10737 || ang >= 10737 || {n, o} !== 2'b00) begin
      n_fail++;
      $display("FAIL big_20pi: quad=%0d angle=%0d nan=%b oor=%b want quad 0 |angle|<10737",
               q, ang, n, o);
    end
    for (int i = 0; i < 3; i++) begin
      run_vec(zv[i], ang, q, n, o, lat);
      n_checks++;
      if (ang !== 0 || q !== 2'd0 || {n, o} !== 2'b00 || lat !== 3) begin
        n_fail++;
        $display("FAIL zero_%h: angle=%0d quad=%0d nan=%b oor=%b lat=%0d want 0 0 0 0 3",
                 zv[i], ang, q, n, o, lat);
      end
    end
  endtask

  task automatic test_special;
    int ang, lat;
    logic [1:0] q;
    logic n, o;
    logic [31:0] nv [2];
    logic [31:0] ov [2];
    nv[0] = 32'h7fc00000;
    nv[1] = 32'hff800000;
    ov[0] = 32'h43000000;
    ov[1] = 32'hc3000000;
    for (int i = 0; i < 2; i++) begin
      run_vec(nv[i], ang, q, n, o, lat);
      n_checks++;
      if (n !== 1'b1 || o !== 1'b0 || ang !== 0 || q !== 2'd0) begin
        n_fail++;
        $display("FAIL nan_%h: nan=%b oor=%b angle=%0d quad=%0d want 1 0 0 0",
                 nv[i], n, o, ang, q);
      end
    end
    for (int i = 0; i < 2; i++) begin
      run_vec(ov[i], ang, q, n, o, lat);
      n_checks++;
      if (o !== 1'b1 || n !== 1'b0 || ang !== 0 || q !== 2'd0) begin
        n_fail++;
        $display("FAIL oor_%h: oor=%b nan=%b angle=%0d quad=%0d want 1 0 0 0",
                 ov[i], o, n, ang, q);
      end
    end
    // 127.0 = 81*pi/2 - 0.2345 rad
    run_vec(32'h42fe0000, ang, q, n, o, lat);
    n_checks++;
    if (o !== 1'b0 || n !== 1'b0 || q !== 2'd1 ||
        ang < -251795110 - 64 || ang > -251795110 + 64) begin
      n_fail++;
      $display("FAIL in_127: oor=%b quad=%0d angle=%0d want 0 1 -251795110",
               o, q, ang);
    end
    // Largest finite in-range value, 128 - 2^-17
    run_vec(32'h42ffffff, ang, q, n, o, lat);
    n_checks++;
    if (o !== 1'b0 || n !== 1'b0 || q !== 2'd1 ||
        ang < 821938522 - 64 || ang > 821938522 + 64) begin
      n_fail++;
      $display("FAIL in_max: oor=%b quad=%0d angle=%0d want 0 1 821938522",
               o, q, ang);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vec [64];
    int          exp_q [64];
    real         exp_a [64];
    int          sent, got, cyc, nn, b;
    real         xr, kr, d;
    logic        hold_v;
    logic [35:0] hold_d;
    logic        want_rdy;
    for (int i = 0; i < 64; i++) begin
      nn = i + 1;
      b  = 0;
      for (int j = 0; j < 7; j++)
        if (nn >= (1 << j)) b = j;
      vec[i]   = {i[0], 8'(127 + b), 23'(nn << (23 - b))};
      xr       = (i[0] ? -1.0 : 1.0) * nn;
      kr       = $floor(xr * 2.0 / PI + 0.5);
      exp_q[i] = int'(kr) & 3;
      exp_a[i] = (xr - kr * PI / 2.0) * 1073741824.0;
    end
    sent = 0;
    got = 0;
    cyc = 0;
    hold_v = 1'b0;
    hold_d = '0;
    while (got < 64 && cyc < 3000) begin
      @(posedge clock); #1;
      io_in_valid  = (sent < 64);
      io_in_bits   = vec[(sent < 64) ? sent : 63];
      io_out_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (hold_v) begin
        n_checks++;
        if (io_out_valid !== 1'b1 ||
            {io_out_angle, io_out_quadrant, io_out_nan, io_out_oor} !== hold_d) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b data=%h want 1 %h", io_out_valid,
                   {io_out_angle, io_out_quadrant, io_out_nan, io_out_oor}, hold_d);
        end
      end
      want_rdy = !((sent - got) == 3 && !io_out_ready);
      n_checks++;
      if (io_in_ready !== want_rdy) begin
        n_fail++;
        $display("FAIL stream_in_ready: got %b want %b (in flight %0d)",
                 io_in_ready, want_rdy, sent - got);
      end
      if (io_out_valid && io_out_ready) begin
        d = $itor($signed(io_out_angle)) - exp_a[got];
        n_checks++;
        if (io_out_quadrant !== exp_q[got][1:0] || io_out_nan !== 1'b0 ||
            io_out_oor !== 1'b0 || d > 64.0 || d < -64.0) begin
          n_fail++;
          $display("FAIL stream_item%0d: quad=%0d angle=%0d want quad=%0d angle=%0.0f",
                   got, io_out_quadrant, $signed(io_out_angle), exp_q[got], exp_a[got]);
        end
        got++;
      end
      hold_v = io_out_valid && !io_out_ready;
      hold_d = {io_out_angle, io_out_quadrant, io_out_nan, io_out_oor};
      if (io_in_valid && io_in_ready) sent++;
      cyc++;
    end
    n_checks++;
    if (got !== 64 || sent !== 64) begin
      n_fail++;
      $display("FAIL stream_count: sent=%0d got=%0d want 64 64", sent, got);
    end
    @(posedge clock); #1;
    io_in_valid  = 1'b0;
    io_out_ready = 1'b1;
    #1;
    n_checks++;
    if (io_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_extra: valid=%b want 0 after drain", io_out_valid);
    end
  endtask

  task automatic test_mid_reset;
    int ang, lat;
    logic [1:0] q;
    logic n, o;
    io_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      io_in_valid = 1'b1;
      io_in_bits  = 32'h7fc00000;
      @(posedge clock); #1;
    end
    io_in_valid = 1'b0;
    n_checks++;
    if (io_out_valid !== 1'b1 || io_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill: valid=%b in_ready=%b want 1 0", io_out_valid, io_in_ready);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1 || io_out_nan !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b in_ready=%b nan=%b want 0 1 0",
               io_out_valid, io_in_ready, io_out_nan);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    run_vec(32'h42fe0000, ang, q, n, o, lat);
    n_checks++;
    if (lat !== 3 || n !== 1'b0 || q !== 2'd1 ||
        ang < -251795110 - 64 || ang > -251795110 + 64) begin
      n_fail++;
      $display("FAIL post_reset: lat=%0d nan=%b quad=%0d angle=%0d want 3 0 1 -251795110",
               lat, n, q, ang);
    end
  endtask

  initial begin
    test_reset();
    test_mid_range();
    test_large_zero();
    test_special();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
